pipe_stage_hs: RTL and testbench

//  Parametrised inter-stage pipeline register for the 5-stage CPU (F/D, D/E, E/M, M/W).

---
 rtl/cpu_pipe_pkg.sv | 44 ++++
 rtl/pipe_sat_counter.sv | 25 ++
 rtl/pipe_stage_hs.sv | 131 +++++++++++++
 tb/tb_pipe_stage_hs.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the CPU inter-stage pipeline registers: stage bus layouts,
// bubble payloads and the skid-buffer state encoding.
package cpu_pipe_pkg;

    localparam int unsigned PIPE_DATA_W = 128;

    localparam logic [31:0] NOP_IR  = 32'h0000_0000;
    localparam logic [31:0] RST_PC4 = 32'h0000_3004;

    // F/D bus: IR, PC+4
    localparam int unsigned FD_IR_LSB  = 0;
    localparam int unsigned FD_PC4_LSB = 32;

    // D/E bus: IR, PC+4, V1, V2
    localparam int unsigned DE_IR_LSB  = 0;
    localparam int unsigned DE_PC4_LSB = 32;
    localparam int unsigned DE_V1_LSB  = 64;
    localparam int unsigned DE_V2_LSB  = 96;

    // E/M bus: IR, PC+4, ALU result, V2 (store data)
    localparam int unsigned EM_IR_LSB  = 0;
    localparam int unsigned EM_PC4_LSB = 32;
    localparam int unsigned EM_ALU_LSB = 64;
    localparam int unsigned EM_V2_LSB  = 96;

    // M/W bus: IR, PC+4, ALU result, memory read data
    localparam int unsigned MW_IR_LSB  = 0;
    localparam int unsigned MW_PC4_LSB = 32;
    localparam int unsigned MW_ALU_LSB = 64;
    localparam int unsigned MW_DM_LSB  = 96;

    // Bubble payloads: a NOP carrying the reset PC+4 so downstream never sees garbage.
    localparam logic [PIPE_DATA_W-1:0] FD_RST_DATA = {64'h0, RST_PC4, NOP_IR};
    localparam logic [PIPE_DATA_W-1:0] DE_RST_DATA = {32'h0, 32'h0, RST_PC4, NOP_IR};
    localparam logic [PIPE_DATA_W-1:0] EM_RST_DATA = {32'h0, 32'h0, RST_PC4, NOP_IR};
    localparam logic [PIPE_DATA_W-1:0] MW_RST_DATA = {32'h0, 32'h0, RST_PC4, NOP_IR};

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_FULL  = 2'b11
    } skid_state_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter used for the stage stall statistic; sticks at all-ones.
module pipe_sat_counter #(
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   inc,
    output logic [STALL_CNT_W-1:0] cnt
);

    localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [STALL_CNT_W-1:0] sat_incr(input logic [STALL_CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= sat_incr(cnt);
        end
    end

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready inter-stage pipeline register with flush-to-bubble, optional 2-entry skid
// buffer (registered in_ready) and a saturating stall counter.
module pipe_stage_hs
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned       DATA_W      = 128,
    parameter logic [DATA_W-1:0] RST_DATA    = '0,
    parameter bit                SKID        = 1'b1,
    parameter int unsigned       STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    if (SKID) begin : g_skid
        skid_state_e       state_p0, state_nxt;
        logic [DATA_W-1:0] main_p0, main_nxt;
        logic [DATA_W-1:0] skid_p0, skid_nxt;
        logic              rdy_p0;
        logic              xfer_in, xfer_out;

        assign xfer_in  = in_valid && rdy_p0;
        assign xfer_out = (state_p0 != SKID_EMPTY) && out_ready;

        // Vacated entries are rewritten with RST_DATA so out_data never shows stale payload.
        always_comb begin
            state_nxt = state_p0;
            main_nxt  = main_p0;
            skid_nxt  = skid_p0;
            if (flush) begin
                state_nxt = SKID_EMPTY;
                main_nxt  = RST_DATA;
                skid_nxt  = RST_DATA;
            end else begin
                case (state_p0)
                    SKID_EMPTY: begin
                        if (xfer_in) begin
                            state_nxt = SKID_ONE;
                            main_nxt  = in_data;
                        end
                    end
                    SKID_ONE: begin
                        if (xfer_in && xfer_out) begin
                            main_nxt = in_data;
                        end else if (xfer_in) begin
                            state_nxt = SKID_FULL;
                            skid_nxt  = in_data;
                        end else if (xfer_out) begin
                            state_nxt = SKID_EMPTY;
                            main_nxt  = RST_DATA;
                        end
                    end
                    SKID_FULL: begin
                        if (xfer_out) begin
                            state_nxt = SKID_ONE;
                            main_nxt  = skid_p0;
                            skid_nxt  = RST_DATA;
                        end
                    end
                    default: begin
                        state_nxt = SKID_EMPTY;
                        main_nxt  = RST_DATA;
                        skid_nxt  = RST_DATA;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_p0 <= SKID_EMPTY;
                main_p0  <= RST_DATA;
                skid_p0  <= RST_DATA;
                rdy_p0   <= 1'b1;
            end else begin
                state_p0 <= state_nxt;
                main_p0  <= main_nxt;
                skid_p0  <= skid_nxt;
                rdy_p0   <= (state_nxt != SKID_FULL);
            end
        end

        assign in_ready  = rdy_p0;
        assign out_valid = (state_p0 != SKID_EMPTY);
        assign out_data  = main_p0;
    end else begin : g_single
        logic              vld_p0;
        logic [DATA_W-1:0] main_p0;
        logic              xfer_in;

        assign in_ready = !vld_p0 || out_ready;
        assign xfer_in  = in_valid && in_ready;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                vld_p0  <= 1'b0;
                main_p0 <= RST_DATA;
            end else if (flush) begin
                vld_p0  <= 1'b0;
                main_p0 <= RST_DATA;
            end else if (xfer_in) begin
                vld_p0  <= 1'b1;
                main_p0 <= in_data;
            end else if (vld_p0 && out_ready) begin
                vld_p0  <= 1'b0;
                main_p0 <= RST_DATA;
            end
        end

        assign out_valid = vld_p0;
        assign out_data  = main_p0;
    end

    pipe_sat_counter #(
        .STALL_CNT_W(STALL_CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (out_valid && !out_ready),
        .cnt     (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: three instances (SKID=0, SKID=1, SKID=1 with 3-bit stall counter),
// one active at a time, with a FIFO scoreboard on the active instance.
module tb_pipe_stage_hs;

    localparam int unsigned W = 32;
    localparam logic [W-1:0] RSTD = 32'hDEAD_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n, iv, ordy, fl, mon_en;
    logic [W-1:0] idata;
    int           sel;

    logic         iv0, iv1, iv2, fl0, fl1, fl2;
    logic         ir0, ir1, ir2, ov0, ov1, ov2;
    logic [W-1:0] od0, od1, od2;
    logic [15:0]  sc0, sc1;
    logic [2:0]   sc2;

    assign iv0 = iv && (sel == 0);
    assign iv1 = iv && (sel == 1);
    assign iv2 = iv && (sel == 2);
    assign fl0 = fl && (sel == 0);
    assign fl1 = fl && (sel == 1);
    assign fl2 = fl && (sel == 2);

    pipe_stage_hs #(.DATA_W(W), .RST_DATA(RSTD), .SKID(1'b0), .STALL_CNT_W(16)) u_s0 (
        .clk(clk), .reset_n(reset_n), .flush(fl0), .in_valid(iv0), .in_ready(ir0),
        .in_data(idata), .out_valid(ov0), .out_ready(ordy), .out_data(od0), .stall_cnt(sc0));

    pipe_stage_hs #(.DATA_W(W), .RST_DATA(RSTD), .SKID(1'b1), .STALL_CNT_W(16)) u_s1 (
        .clk(clk), .reset_n(reset_n), .flush(fl1), .in_valid(iv1), .in_ready(ir1),
        .in_data(idata), .out_valid(ov1), .out_ready(ordy), .out_data(od1), .stall_cnt(sc1));

    pipe_stage_hs #(.DATA_W(W), .RST_DATA(RSTD), .SKID(1'b1), .STALL_CNT_W(3)) u_s2 (
        .clk(clk), .reset_n(reset_n), .flush(fl2), .in_valid(iv2), .in_ready(ir2),
        .in_data(idata), .out_valid(ov2), .out_ready(ordy), .out_data(od2), .stall_cnt(sc2));

    logic         m_ov, m_ir;
    logic [W-1:0] m_od;
    always_comb begin
        m_ov = ov0;
        m_ir = ir0;
        m_od = od0;
        case (sel)
            1: begin m_ov = ov1; m_ir = ir1; m_od = od1; end
            2: begin m_ov = ov2; m_ir = ir2; m_od = od2; end
            default: ;
        endcase
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: accepted payloads queue up; every output transfer must pop the oldest one.
    logic [W-1:0] q[$];
    always @(negedge clk) begin
        if (!reset_n) begin
            q.delete();
        end else if (mon_en) begin
            if (m_ov && ordy) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: got %h expected no output (t=%0t)", m_od, $time);
                end else begin
                    chk("sb_order", m_od, q.pop_front());
                end
            end
            if (!m_ov) chk("bubble_data", m_od, RSTD);
            if (fl) q.delete();
            else if (iv && m_ir) q.push_back(idata);
        end
    end

    logic [31:0] base;

    initial begin
        reset_n = 1'b0; iv = 1'b0; ordy = 1'b0; fl = 1'b0; idata = '0; sel = 0; mon_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        cyc();

        // Reset asserted mid-cycle while holding a stalled payload
        sel = 1; ordy = 1'b0;
        iv = 1'b1; idata = 32'h11;
        cyc();
        iv = 1'b0;
        cyc();
        cyc();
        chk("rst_pre_stall", 32'(sc1), 32'd2);
        chk("rst_pre_valid", 32'(ov1), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_ov1", 32'(ov1), 32'd0);
        chk("rst_od1", od1, RSTD);
        chk("rst_ir1", 32'(ir1), 32'd1);
        chk("rst_sc1", 32'(sc1), 32'd0);
        chk("rst_ov0", 32'(ov0), 32'd0);
        chk("rst_od0", od0, RSTD);
        chk("rst_ir0", 32'(ir0), 32'd1);
        chk("rst_sc0", 32'(sc0), 32'd0);
        chk("rst_sc2", 32'(sc2), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cyc();

        // Streaming 1..8, one per cycle, both modes
        ordy = 1'b1;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            chk("stream_idle", 32'(m_ov), 32'd0);
            for (int i = 1; i <= 8; i++) begin
                iv = 1'b1; idata = 32'(i);
                cyc();
                chk("stream_valid", 32'(m_ov), 32'd1);
                chk("stream_data", m_od, 32'(i));
                chk("stream_ready", 32'(m_ir), 32'd1);
            end
            iv = 1'b0;
            cyc();
            chk("stream_end_valid", 32'(m_ov), 32'd0);
            chk("stream_end_data", m_od, RSTD);
            chk("stream_drain", 32'(q.size()), 32'd0);
        end

        // Backpressure into the skid buffer
        sel = 1; ordy = 1'b0;
        base = 32'(sc1);
        iv = 1'b1; idata = 32'hA;
        cyc();
        chk("bp_ir_one", 32'(ir1), 32'd1);
        chk("bp_od_a", od1, 32'hA);
        idata = 32'hB;
        cyc();
        iv = 1'b0;
        chk("bp_ir_full", 32'(ir1), 32'd0);
        chk("bp_od_hold", od1, 32'hA);
        repeat (4) cyc();
        chk("bp_stall5", 32'(sc1), base + 32'd5);
        ordy = 1'b1;
        cyc();
        chk("bp_od_b", od1, 32'hB);
        chk("bp_ov_b", 32'(ov1), 32'd1);
        chk("bp_ir_back", 32'(ir1), 32'd1);
        chk("bp_stall_hold", 32'(sc1), base + 32'd5);
        cyc();
        chk("bp_empty", 32'(ov1), 32'd0);
        chk("bp_empty_data", od1, RSTD);

        // Backpressure on the single register: combinational in_ready
        sel = 0; ordy = 1'b0;
        iv = 1'b1; idata = 32'hA;
        cyc();
        idata = 32'hB;
        cyc();
        chk("bp0_ir_blocked", 32'(ir0), 32'd0);
        chk("bp0_od_a", od0, 32'hA);
        ordy = 1'b1;
        #1;
        chk("bp0_ir_comb", 32'(ir0), 32'd1);
        cyc();
        chk("bp0_od_b", od0, 32'hB);
        iv = 1'b0;
        cyc();
        chk("bp0_empty", 32'(ov0), 32'd0);

        // Flush from FULL with a simultaneous input; the held head still leaves
        sel = 1; ordy = 1'b0;
        iv = 1'b1; idata = 32'hA;
        cyc();
        idata = 32'hB;
        cyc();
        iv = 1'b0;
        cyc();
        chk("fl_full", 32'(ir1), 32'd0);
        base = 32'(sc1);
        fl = 1'b1; iv = 1'b1; idata = 32'hC; ordy = 1'b1;
        cyc();
        fl = 1'b0; iv = 1'b0;
        chk("fl_ov", 32'(ov1), 32'd0);
        chk("fl_od", od1, RSTD);
        chk("fl_ir", 32'(ir1), 32'd1);
        chk("fl_stall", 32'(sc1), base);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("fl_no_c", 32'(ov1), 32'd0);
        end

        // Flush on the single register, held payload and on empty with input
        sel = 0; ordy = 1'b0;
        iv = 1'b1; idata = 32'hA;
        cyc();
        fl = 1'b1; idata = 32'hC;
        cyc();
        chk("fl0_held_ov", 32'(ov0), 32'd0);
        chk("fl0_held_od", od0, RSTD);
        chk("fl0_ir", 32'(ir0), 32'd1);
        cyc();
        fl = 1'b0; iv = 1'b0;
        chk("fl0_empty_ov", 32'(ov0), 32'd0);
        ordy = 1'b1;
        cyc();

        // Stall counter saturation at 3 bits
        sel = 2; ordy = 1'b0;
        iv = 1'b1; idata = 32'h55;
        cyc();
        iv = 1'b0;
        chk("sat_start", 32'(sc2), 32'd0);
        repeat (6) cyc();
        chk("sat_6", 32'(sc2), 32'd6);
        repeat (4) cyc();
        chk("sat_10", 32'(sc2), 32'd7);
        repeat (3) cyc();
        chk("sat_hold", 32'(sc2), 32'd7);
        ordy = 1'b1;
        repeat (2) cyc();
        chk("sat_drain", 32'(ov2), 32'd0);

        // Random valid/ready with occasional flush, both modes
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int n = 0; n < 10000; n++) begin
                iv    = ($urandom_range(0, 1) == 1);
                idata = $urandom;
                ordy  = ($urandom_range(0, 3) != 0) || (n % 97 < 10 ? 1'b0 : 1'b0);
                if (n % 500 < 20) ordy = 1'b0;
                fl    = ($urandom_range(0, 127) == 0);
                cyc();
            end
            iv = 1'b0; fl = 1'b0; ordy = 1'b1;
            repeat (4) cyc();
            chk("rand_drain", 32'(q.size()), 32'd0);
            chk("rand_idle", 32'(m_ov), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
